uart_baud_gen_frac: RTL

//   Parametrised fractional baud/oversample tick generator for the UART TX/RX paths.

---
 rtl/uart_baud_gen_frac.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_baud_gen_frac.sv
// Fractional oversample tick generator for the UART: divides Clk by Div_int + Div_frac/2^FRAC_W
// and derives per-bit and mid-bit ticks from the oversample phase.
module uart_baud_gen_frac #(
  parameter  int DIV_W        = 16,
  parameter  int FRAC_W       = 4,
  parameter  int OVS          = 16,
  parameter  int DEF_DIV_INT  = 325,
  parameter  int DEF_DIV_FRAC = 0,
  localparam int PH_W         = (OVS > 1) ? $clog2(OVS) : 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic [DIV_W-1:0]  Div_int,
  input  logic [FRAC_W-1:0] Div_frac,
  input  logic              Div_load,
  input  logic              Rx_resync,
  output logic              Tick_ovs,
  output logic              Tick_bit,
  output logic              Tick_mid,
  output logic [PH_W-1:0]   Ovs_phase,
  output logic              Div_err
);

  localparam logic [DIV_W:0]  CNT_ONE  = (DIV_W+1)'(1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_MID   = PH_W'(OVS / 2 - 1);

  logic [DIV_W:0]    cnt_q, cnt_d, period;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d, pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
  logic              pend_vld_q, pend_vld_d;
  logic              run, tick, bad_load, load_ok, apply_ev;

  always_comb begin
    acc_sum  = {1'b0, acc_q} + {1'b0, act_frac_q};
    period   = {1'b0, act_int_q} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
    run      = En && !Rx_resync;
    tick     = run && (cnt_q == period - CNT_ONE);
    bad_load = Div_load && (Div_int < DIV_W'(2));
    load_ok  = Div_load && !bad_load;
    apply_ev = tick || !En || Rx_resync;

    cnt_d       = cnt_q + CNT_ONE;
    acc_d       = acc_q;
    phase_d     = phase_q;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_vld_d  = pend_vld_q;

    if (!run) begin
      cnt_d   = '0;
      acc_d   = '0;
      phase_d = '0;
    end else if (tick) begin
      cnt_d   = '0;
      acc_d   = acc_sum[FRAC_W-1:0];
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
    end

    // Divisor changes only land on interval boundaries so no interval is cut or stretched.
    if (apply_ev) begin
      if (load_ok) begin
        act_int_d  = Div_int;
        act_frac_d = Div_frac;
        pend_vld_d = 1'b0;
        acc_d      = '0;
      end else if (pend_vld_q) begin
        act_int_d  = pend_int_q;
        act_frac_d = pend_frac_q;
        pend_vld_d = 1'b0;
        acc_d      = '0;
      end
    end else if (load_ok) begin
      pend_int_d  = Div_int;
      pend_frac_d = Div_frac;
      pend_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      phase_q     <= '0;
      act_int_q   <= DIV_W'(DEF_DIV_INT);
      act_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_vld_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_vld_q  <= pend_vld_d;
    end
  end

  assign Tick_ovs  = tick;
  assign Tick_bit  = tick && (phase_q == PH_LAST);
  assign Tick_mid  = tick && (phase_q == PH_MID);
  assign Ovs_phase = phase_q;
  assign Div_err   = bad_load;

endmodule
